// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Sequencer for the DDS phase-increment word. Replaces the static frequency
//   select on the accumulator's inc input with one of four programs:
//   fixed tone, sawtooth sweep, triangle sweep or single-shot sweep. Each
//   frequency is held for dwell+1 cycles and every new inc value is flagged.
//
// Ports
//   clk      in   1        system (DDS) clock
//   rst_n    in   1        synchronous reset, active-low
//   start    in   1        pulse: latch config and (re)start the sequence
//   stop     in   1        pulse: abort to idle, inc frozen (wins over start)
//   mode     in   2        00 fixed, 01 saw, 10 triangle, 11 single-shot
//   f_start  in   W        start / fixed tuning word
//   f_stop   in   W        sweep upper bound (inclusive)
//   f_step   in   W        sweep increment
//   dwell    in   DWELL_W  each frequency is held dwell+1 cycles
//   inc      out  W        phase increment to the accumulator (registered)
//   inc_upd  out  1        pulse in the first cycle a new inc value appears
//   busy     out  1        high while in FIXED or SWEEP
//   done     out  1        pulse when a single-shot sweep completes
//   dir      out  1        sweep direction, 1 = up
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int W       = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [W-1:0]       f_start,
    input  logic [W-1:0]       f_stop,
    input  logic [W-1:0]       f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [W-1:0]       inc,
    output logic               inc_upd,
    output logic               busy,
    output logic               done,
    output logic               dir
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIXED = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

    localparam logic [1:0] MODE_FIXED  = 2'b00;
    localparam logic [1:0] MODE_SAW    = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_SINGLE = 2'b11;

    // Sequencer state and outputs
    logic [1:0]         state_q,   state_d;
    logic [W-1:0]       inc_q,     inc_d;
    logic               inc_upd_q, inc_upd_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               dir_q,     dir_d;
    logic [DWELL_W-1:0] cnt_q,     cnt_d;

    // Configuration captured at start; inputs are ignored until the next start
    logic [1:0]         mode_q,    mode_d;
    logic [W-1:0]       f_start_q, f_start_d;
    logic [W-1:0]       f_stop_q,  f_stop_d;
    logic [W-1:0]       f_step_q,  f_step_d;
    logic [DWELL_W-1:0] dwell_q,   dwell_d;

    // Next-step candidates carry one extra bit so that a carry out of the top
    // (up) or a borrow below zero (dn) is visible to the bound compares and
    // the sweep can never wrap through 2^W.
    logic [W:0] up_w;
    logic [W:0] dn_w;
    logic       up_over;   // inc + f_step would pass f_stop
    logic       dn_under;  // inc - f_step would fall below f_start (or borrow)

    assign up_w     = {1'b0, inc_q} + {1'b0, f_step_q};
    assign dn_w     = {1'b0, inc_q} - {1'b0, f_step_q};
    assign up_over  = up_w > {1'b0, f_stop_q};
    assign dn_under = dn_w[W] || (dn_w[W-1:0] < f_start_q);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default here first;
        // a path that left one unassigned would infer a latch.
        state_d   = state_q;
        inc_d     = inc_q;
        inc_upd_d = 1'b0;
        done_d    = 1'b0;
        dir_d     = dir_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        f_start_d = f_start_q;
        f_stop_d  = f_stop_q;
        f_step_d  = f_step_q;
        dwell_d   = dwell_q;

        if (stop) begin
            // Abort: inc freezes at its current value, no strobe
            state_d = ST_IDLE;
        end else if (start) begin
            mode_d    = mode;
            f_start_d = f_start;
            f_stop_d  = f_stop;
            f_step_d  = f_step;
            dwell_d   = dwell;
            inc_d     = f_start;
            inc_upd_d = 1'b1;
            dir_d     = 1'b1;
            cnt_d     = dwell;
            // A sweep that cannot advance (zero step or empty range) degrades
            // to a fixed tone at f_start.
            if (mode == MODE_FIXED || f_step == '0 || f_start > f_stop) begin
                state_d = ST_FIXED;
            end else begin
                state_d = ST_SWEEP;
            end
        end else if (state_q == ST_SWEEP) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - DWELL_W'(1);
            end else begin
                cnt_d     = dwell_q;
                inc_upd_d = 1'b1;
                case (mode_q)
                    MODE_SAW: begin
                        inc_d = up_over ? f_start_q : up_w[W-1:0];
                    end
                    MODE_TRI: begin
                        if (dir_q) begin
                            if (up_over) begin
                                // Turn at the top: step down, but not below f_start
                                dir_d = 1'b0;
                                inc_d = dn_under ? f_start_q : dn_w[W-1:0];
                            end else begin
                                inc_d = up_w[W-1:0];
                            end
                        end else begin
                            if (dn_under) begin
                                // Turn at the bottom: step up, but not above f_stop
                                dir_d = 1'b1;
                                inc_d = up_over ? f_stop_q : up_w[W-1:0];
                            end else begin
                                inc_d = dn_w[W-1:0];
                            end
                        end
                    end
                    MODE_SINGLE: begin
                        if (up_over) begin
                            // Sweep finished: hold the last value, report done
                            state_d   = ST_IDLE;
                            done_d    = 1'b1;
                            inc_upd_d = 1'b0;
                            cnt_d     = cnt_q;
                        end else begin
                            inc_d = up_w[W-1:0];
                        end
                    end
                    default: begin
                        // Fixed mode never enters SWEEP; hold everything
                        inc_upd_d = 1'b0;
                        cnt_d     = cnt_q;
                    end
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of its inputs regardless of order.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            inc_q     <= '0;
            inc_upd_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dir_q     <= 1'b1;
            cnt_q     <= '0;
            // NOTE: the config shadow registers are reset as well, even though
            // they are only consumed after a start, so no X can reach the
            // arithmetic in simulation or after power-up.
            mode_q    <= MODE_FIXED;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
        end else begin
            state_q   <= state_d;
            inc_q     <= inc_d;
            inc_upd_q <= inc_upd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dir_q     <= dir_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            f_start_q <= f_start_d;
            f_stop_q  <= f_stop_d;
            f_step_q  <= f_step_d;
            dwell_q   <= dwell_d;
        end
    end

    assign inc     = inc_q;
    assign inc_upd = inc_upd_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign dir     = dir_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Self-checking bench for dds_sweep_ctrl. Each scenario queues the expected
//   per-cycle output tuple {inc, inc_upd, busy, done, dir} as it drives the
//   stimulus, then pops and compares one entry per clock, sampled 1 time unit
//   after the rising edge.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int W  = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [W-1:0]  f_start;
    logic [W-1:0]  f_stop;
    logic [W-1:0]  f_step;
    logic [DW-1:0] dwell;
    logic [W-1:0]  inc;
    logic          inc_upd;
    logic          busy;
    logic          done;
    logic          dir;

    typedef struct packed {
        logic [W-1:0] inc;
        logic         upd;
        logic         busy;
        logic         done;
        logic         dir;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    dds_sweep_ctrl #(.W(W), .DWELL_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .f_start (f_start),
        .f_stop  (f_stop),
        .f_step  (f_step),
        .dwell   (dwell),
        .inc     (inc),
        .inc_upd (inc_upd),
        .busy    (busy),
        .done    (done),
        .dir     (dir)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [W-1:0] v, input logic u, input logic b,
                        input logic d, input logic r);
        obs_t o;
        o.inc  = v;
        o.upd  = u;
        o.busy = b;
        o.done = d;
        o.dir  = r;
        exp_q.push_back(o);
    endtask

    // An empty queue yields an all-ones tuple (busy and done both high),
    // which the DUT can never produce.
    function automatic obs_t pop();
        if (exp_q.size() != 0) return exp_q.pop_front();
        return '1;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("inc=%h upd=%b busy=%b done=%b dir=%b",
                         o.inc, o.upd, o.busy, o.done, o.dir);
    endfunction

    // Advance one clock, drop the one-cycle pulses, sample the outputs.
    task automatic step(output obs_t act);
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        act   = {inc, inc_upd, busy, done, dir};
    endtask

    task automatic configure(input logic [1:0] m, input logic [W-1:0] fs,
                             input logic [W-1:0] fe, input logic [W-1:0] st,
                             input logic [DW-1:0] dw);
        mode    = m;
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
    endtask

    task automatic test_reset();
        obs_t act, e;
        // Power-on reset
        rst_n = 1'b0;
        repeat (2) push('0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL reset_por[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        rst_n = 1'b1;
        // Start a saw sweep, then reset in the middle of it for three cycles
        configure(2'b01, 100, 130, 10, 2);
        push(100, 1, 1, 0, 1); push(100, 0, 1, 0, 1); push(100, 0, 1, 0, 1);
        push(110, 1, 1, 0, 1); push(110, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL reset_pre[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        rst_n = 1'b0;
        repeat (3) push('0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL reset_mid[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        rst_n = 1'b1;
        repeat (2) push('0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL reset_idle[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_fixed();
        obs_t act, e;
        configure(2'b00, 32'h0002_9F17, 0, 0, 0);
        push(32'h0002_9F17, 1, 1, 0, 1);
        repeat (100) push(32'h0002_9F17, 0, 1, 0, 1);
        for (int i = 0; i < 101; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL fixed[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        stop = 1'b1;
        repeat (2) push(32'h0002_9F17, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL fixed_stop[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_saw();
        obs_t act, e;
        logic [W-1:0] vals [6] = '{100, 110, 120, 130, 100, 110};
        configure(2'b01, 100, 130, 10, 2);
        foreach (vals[k]) begin
            push(vals[k], 1, 1, 0, 1);
            repeat (2) push(vals[k], 0, 1, 0, 1);
        end
        for (int i = 0; i < 18; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL saw[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
            if (i == 0) begin
                // Config inputs must be ignored outside a start cycle
                mode = 2'b10; f_start = 7; f_stop = 9; f_step = 1; dwell = 0;
            end
        end
    endtask

    task automatic test_triangle();
        obs_t act, e;
        logic [W-1:0] vals [8] = '{100, 112, 124, 112, 100, 112, 124, 112};
        logic         dirs [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
        configure(2'b10, 100, 130, 12, 0);
        foreach (vals[k]) push(vals[k], 1, 1, 0, dirs[k]);
        for (int i = 0; i < 8; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL triangle[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_single_shot();
        obs_t act, e;
        configure(2'b11, 100, 130, 10, 0);
        push(100, 1, 1, 0, 1); push(110, 1, 1, 0, 1);
        push(120, 1, 1, 0, 1); push(130, 1, 1, 0, 1);
        push(130, 0, 0, 1, 1);
        repeat (2) push(130, 0, 0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL single[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_invalid_config();
        obs_t act, e;
        // Zero step in saw mode runs as a fixed tone
        configure(2'b01, 200, 300, 0, 1);
        push(200, 1, 1, 0, 1);
        repeat (5) push(200, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL step0[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        // Empty range (f_start > f_stop) in triangle mode runs as a fixed tone
        configure(2'b10, 500, 400, 5, 0);
        push(500, 1, 1, 0, 1);
        repeat (3) push(500, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL badrange[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_back_to_back();
        obs_t act, e;
        configure(2'b01, 100, 130, 10, 0);
        push(100, 1, 1, 0, 1); push(110, 1, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL b2b_first[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        // Restart while busy
        configure(2'b01, 100, 130, 10, 0);
        push(100, 1, 1, 0, 1); push(110, 1, 1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL b2b_restart[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
        // start and stop together: stop wins, inc frozen
        configure(2'b01, 300, 400, 10, 0);
        stop = 1'b1;
        repeat (2) push(110, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL start_stop[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    task automatic test_wrap();
        obs_t act, e;
        // up would exceed 2^W; must reload f_start rather than wrap to a small value
        configure(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 1);
        push(32'hFFFF_FFFB, 1, 1, 0, 1); push(32'hFFFF_FFFB, 0, 1, 0, 1);
        push(32'hFFFF_FFFB, 1, 1, 0, 1); push(32'hFFFF_FFFB, 0, 1, 0, 1);
        push(32'hFFFF_FFFB, 1, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(act); e = pop(); total++;
            if (act !== e) begin bad++; $display("FAIL wrap[%0d]: got %s want %s", i, fmt(act), fmt(e)); end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'b00;
        f_start = '0;
        f_stop  = '0;
        f_step  = '0;
        dwell   = '0;
        test_reset();
        test_fixed();
        test_saw();
        test_triangle();
        test_single_shot();
        test_invalid_config();
        test_back_to_back();
        test_wrap();
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL leftover: got %0d unconsumed entries want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
